i2c_master_ctrl: RTL and testbench

- Single-byte I2C bus master: one START / 7-bit address / R/W / data byte / STOP frame per `enable` request.
- Drives open-drain SCL and SDA on a bus with external pull-ups and multiple slaves, e.g. slaves at 0x2A, 0x33 and 0x1D.
- Sits between a local host (parallel address/data/handshake) and the shared I2C bus.

---
 rtl/i2c_master_ctrl.sv | 158 +++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C bus master: START / {address, R/W} / data byte / STOP per enable request.
// Defining I2C_MASTER_SVA_EN compiles in embedded protocol assertions.
module i2c_master_ctrl #(
  parameter int DIVIDE_BY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] address,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       ready,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl
);
  localparam int PW = $clog2(DIVIDE_BY);
  localparam logic [PW-1:0] HALF_PH = PW'(DIVIDE_BY / 2);
  localparam logic [PW-1:0] LAST_PH = PW'(DIVIDE_BY - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE_DATA, DATA_ACK, READ_DATA, MASTER_NACK, STOP
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    data_out_q, data_out_d;

  logic       sda_in;
  logic       sda_low, scl_low;
  logic       bit_end;
  logic [2:0] bit_idx;
  logic [7:0] addr_byte;

  assign sda_in    = i2c_sda;
  assign bit_end   = (phase_q == LAST_PH);
  assign bit_idx   = 3'd7 - bit_q;
  assign addr_byte = {addr_q, rw_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ACK/NACK is sampled straight off the bus on the last phase, while SCL is high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (enable) state_d = START;
      START:       if (bit_end) state_d = ADDR;
      ADDR:        if (bit_end && bit_q == 3'd7) state_d = ADDR_ACK;
      ADDR_ACK:    if (bit_end) state_d = sda_in ? STOP : (rw_q ? READ_DATA : WRITE_DATA);
      WRITE_DATA:  if (bit_end && bit_q == 3'd7) state_d = DATA_ACK;
      DATA_ACK:    if (bit_end) state_d = STOP;
      READ_DATA:   if (bit_end && bit_q == 3'd7) state_d = MASTER_NACK;
      MASTER_NACK: if (bit_end) state_d = STOP;
      STOP:        if (bit_end) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    sda_low = 1'b0;
    scl_low = 1'b0;
    case (state_q)
      START: sda_low = (phase_q >= HALF_PH);
      ADDR: begin
        scl_low = (phase_q < HALF_PH);
        sda_low = ~addr_byte[bit_idx];
      end
      WRITE_DATA: begin
        scl_low = (phase_q < HALF_PH);
        sda_low = ~wdata_q[bit_idx];
      end
      ADDR_ACK, DATA_ACK, READ_DATA, MASTER_NACK: scl_low = (phase_q < HALF_PH);
      STOP: begin
        scl_low = (phase_q < HALF_PH);
        sda_low = (phase_q != LAST_PH);
      end
      default: ;
    endcase
  end

  assign i2c_sda  = (sda_low && !rst) ? 1'b0 : 1'bz;
  assign i2c_scl  = (scl_low && !rst) ? 1'b0 : 1'bz;
  assign ready    = (state_q == IDLE) && !rst;
  assign data_out = data_out_q;

  always_comb begin
    phase_d    = (state_q == IDLE || bit_end) ? '0 : phase_q + PW'(1);
    bit_d      = bit_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    if (state_q == IDLE) begin
      bit_d = 3'd0;
      if (enable) begin
        addr_d  = address;
        rw_d    = rw;
        wdata_d = data_in;
      end
    end else if (bit_end) begin
      bit_d = (state_d != state_q) ? 3'd0 : bit_q + 3'd1;
    end
    // The eighth read sample goes straight into data_out without passing through shift_q.
    if (state_q == READ_DATA && bit_end) begin
      shift_d = {shift_q[5:0], sda_in};
      if (bit_q == 3'd7) data_out_d = {shift_q, sda_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      bit_q      <= 3'd0;
      addr_q     <= 7'h00;
      rw_q       <= 1'b0;
      wdata_q    <= 8'h00;
      shift_q    <= 7'h00;
      data_out_q <= 8'h00;
    end else begin
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
    end
  end

`ifdef I2C_MASTER_SVA_EN
  logic edge_state;
  assign edge_state = (state_q == START) || (state_q == STOP);

  a_ready_idle: assert property (@(posedge clk) (state_q != IDLE) |-> !ready)
    else $error("ready high in state %s", state_q.name());
  a_accept: assert property (@(posedge clk) disable iff (rst) (ready && enable) |-> ##[1:2] !ready)
    else $error("request not accepted, state %s", state_q.name());
  a_sda_stable: assert property (@(posedge clk) disable iff (rst)
      (!scl_low && $past(!scl_low) && !edge_state && !$past(edge_state)) |-> $stable(sda_low))
    else $error("SDA moved while SCL high in state %s", state_q.name());
  a_sda_low: assert property (@(posedge clk) disable iff (rst) sda_low |-> (i2c_sda == 1'b0))
    else $error("SDA driven high in state %s", state_q.name());
  a_scl_low: assert property (@(posedge clk) disable iff (rst) scl_low |-> (i2c_scl == 1'b0))
    else $error("SCL driven high in state %s", state_q.name());
  a_reset: assert property (@(posedge clk) rst |=> (state_q == IDLE))
    else $error("not IDLE after reset, state %s", state_q.name());
`endif

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl: three behavioural slaves on a pulled-up bus,
// a negedge monitor that checks each completed frame against queued expectations.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;
  localparam int DIV  = 4;
  localparam int HALF = DIV / 2;

  typedef struct packed {
    logic [7:0]  addr_byte;
    logic [7:0]  data_out;
    logic [23:0] rx;
    logic [7:0]  nacks;
    logic [7:0]  cycles;
    logic [7:0]  pulses;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] address;
  logic [7:0] data_in;
  logic       enable;
  logic       rw;
  logic [7:0] data_out;
  logic       ready;
  wire        i2c_sda;
  wire        i2c_scl;
  logic       slave_sda_low = 1'b0;

  pullup (i2c_sda);
  pullup (i2c_scl);
  assign i2c_sda = slave_sda_low ? 1'b0 : 1'bz;

  i2c_master_ctrl #(.DIVIDE_BY(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_in  (data_in),
    .enable   (enable),
    .rw       (rw),
    .data_out (data_out),
    .ready    (ready),
    .i2c_sda  (i2c_sda),
    .i2c_scl  (i2c_scl)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  logic [6:0] slave_addr [3] = '{7'h2A, 7'h33, 7'h1D};
  logic [7:0] tx_mem     [3] = '{8'hF0, 8'h55, 8'h99};
  logic [7:0] rx_mem     [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] model_rx   [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] model_dout = 8'h00;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Slave/bus monitor state, all owned by the negedge process below.
  logic       sda_now, scl_now;
  logic       sda_prev = 1'b1, scl_prev = 1'b1, ready_prev = 1'b0;
  logic       in_frame = 1'b0;
  int         busy, start_cnt, stop_cnt, pulses, bad_runs, nack_cnt, low_run;
  int         s_ph = 0, s_cnt = 0, s_sel = -1;
  logic       s_rw = 1'b0;
  logic [7:0] s_shift = 8'h00, last_addr_byte = 8'h00;
  exp_t       mon_e;

  // Samples the bus mid-cycle, plays the three slaves, measures each frame and
  // compares it with the oldest queued expectation when ready comes back.
  always @(negedge clk) begin
    sda_now = i2c_sda;
    scl_now = i2c_scl;
    if (rst) begin
      s_ph = 0; slave_sda_low = 1'b0; in_frame = 1'b0; low_run = 0;
    end else begin
      if (!ready && ready_prev && !in_frame) begin
        in_frame = 1'b1; busy = 0; start_cnt = 0; stop_cnt = 0;
        pulses = 0; bad_runs = 0; nack_cnt = 0;
      end
      if (in_frame && !ready) busy++;

      if (scl_now && scl_prev && sda_prev && !sda_now) begin
        start_cnt++; s_ph = 1; s_cnt = 0; s_shift = 8'h00; slave_sda_low = 1'b0;
      end else if (scl_now && scl_prev && !sda_prev && sda_now) begin
        stop_cnt++; s_ph = 0; slave_sda_low = 1'b0;
      end else if (scl_now && !scl_prev) begin
        case (s_ph)
          1, 3: begin s_shift = {s_shift[6:0], sda_now}; s_cnt++; end
          6: if (sda_now) nack_cnt++;
          default: ;
        endcase
      end else if (!scl_now && scl_prev) begin
        pulses++;
        case (s_ph)
          1: if (s_cnt == 8) begin
            last_addr_byte = s_shift;
            s_sel = -1;
            for (int i = 0; i < 3; i++) if (slave_addr[i] == s_shift[7:1]) s_sel = i;
            if (s_sel >= 0) begin s_rw = s_shift[0]; slave_sda_low = 1'b1; s_ph = 2; end
            else s_ph = 0;
          end
          2: begin
            slave_sda_low = 1'b0; s_cnt = 0; s_shift = 8'h00;
            if (s_rw) begin slave_sda_low = !tx_mem[s_sel][7]; s_cnt = 1; s_ph = 5; end
            else s_ph = 3;
          end
          3: if (s_cnt == 8) begin rx_mem[s_sel] = s_shift; slave_sda_low = 1'b1; s_ph = 4; end
          4: begin slave_sda_low = 1'b0; s_ph = 0; end
          5: if (s_cnt < 8) begin slave_sda_low = !tx_mem[s_sel][7 - s_cnt]; s_cnt++; end
             else begin slave_sda_low = 1'b0; s_ph = 6; end
          6: s_ph = 0;
          default: ;
        endcase
      end

      if (!scl_now) low_run++;
      else begin
        if (!scl_prev && in_frame && low_run != HALF) bad_runs++;
        low_run = 0;
      end

      if (ready && !ready_prev && in_frame) begin
        in_frame = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_frame: got a frame, expected none");
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("addr_byte",   last_addr_byte, mon_e.addr_byte);
          checkOutput("data_out",    data_out,  mon_e.data_out);
          checkOutput("rx_2A",       rx_mem[0], mon_e.rx[7:0]);
          checkOutput("rx_33",       rx_mem[1], mon_e.rx[15:8]);
          checkOutput("rx_1D",       rx_mem[2], mon_e.rx[23:16]);
          checkOutput("master_nack", nack_cnt,  mon_e.nacks);
          checkOutput("frame_cycles", busy,     mon_e.cycles);
          checkOutput("scl_pulses",  pulses,    mon_e.pulses);
          checkOutput("scl_low_width_errors", bad_runs, 0);
          checkOutput("start_count", start_cnt, 1);
          checkOutput("stop_count",  stop_cnt,  1);
        end
      end
    end
    sda_prev   = sda_now;
    scl_prev   = scl_now;
    ready_prev = ready;
  end

  // Issues one request and queues what the bus and slaves should show for it.
  task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] d);
    exp_t e;
    int   sel = -1;
    int   guard = 0;
    while (!ready && guard < 400) begin @(posedge clk); #1; guard++; end
    if (!ready) begin
      n_checks++;
      $display("[TB] FAIL ready_timeout: got ready=0, expected 1");
    end
    for (int i = 0; i < 3; i++) if (slave_addr[i] == a) sel = i;
    if (sel >= 0 && !r) model_rx[sel] = d;
    if (sel >= 0 && r)  model_dout = tx_mem[sel];
    e.addr_byte = {a, r};
    e.data_out  = model_dout;
    e.rx        = {model_rx[2], model_rx[1], model_rx[0]};
    e.nacks     = (sel >= 0 && r) ? 8'd1 : 8'd0;
    e.cycles    = (sel >= 0) ? 8'd80 : 8'd44;
    e.pulses    = (sel >= 0) ? 8'd19 : 8'd10;
    exp_q.push_back(e);
    address = a; rw = r; data_in = d; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; address = ~a; rw = ~r; data_in = ~d;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((exp_q.size() != 0 || !ready) && guard < 400) begin @(posedge clk); #1; guard++; end
    if (guard >= 400) begin
      n_checks++;
      $display("[TB] FAIL idle_timeout: got %0d frames pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; address = 7'h00; data_in = 8'h00; rw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", ready, 0);
    checkOutput("reset_scl", i2c_scl, 1);
    checkOutput("reset_sda", i2c_sda, 1);
    checkOutput("reset_data_out", data_out, 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", ready, 1);

    applyStimulus(7'h2A, 1'b0, 8'hA5);
    applyStimulus(7'h33, 1'b0, 8'h3C);
    applyStimulus(7'h1D, 1'b0, 8'h77);
    applyStimulus(7'h2A, 1'b1, 8'h00);
    applyStimulus(7'h33, 1'b1, 8'h00);
    applyStimulus(7'h1D, 1'b1, 8'h00);
    applyStimulus(7'h7F, 1'b0, 8'hC3);
    applyStimulus(7'h7F, 1'b1, 8'h00);
    waitIdle();

    // A request pulsed mid-frame must neither alter this frame nor start another.
    applyStimulus(7'h33, 1'b0, 8'h12);
    repeat (30) @(posedge clk);
    #1 address = 7'h2A; rw = 1'b1; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    waitIdle();
    repeat (10) @(posedge clk);
    #1 checkOutput("idle_after_ignored_enable", ready, 1);

    // Reset in the middle of an address phase abandons the frame outright.
    address = 7'h2A; rw = 1'b0; data_in = 8'h66; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ready", ready, 0);
    checkOutput("abort_scl", i2c_scl, 1);
    checkOutput("abort_sda", i2c_sda, 1);
    checkOutput("abort_data_out", data_out, 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    model_dout = 8'h00;
    @(negedge clk);
    checkOutput("ready_after_abort", ready, 1);

    applyStimulus(7'h1D, 1'b0, 8'h5A);
    waitIdle();
    repeat (10) @(posedge clk);
    #1 checkOutput("frames_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
